// File: rtl/intr_pkg.sv
// Shared codes and defaults for the interrupt-handshake datapath companion.
package intr_pkg;

    typedef enum logic [1:0] {
        CC_IDLE  = 2'b00,
        CC_ENIN  = 2'b01,
        CC_INTR  = 2'b10,
        CC_ACKIN = 2'b11
    } cc_sel_t;

    typedef enum logic [1:0] {
        OUT_NONE    = 2'd0,
        OUT_NORM    = 2'd1,
        OUT_ILLEGAL = 2'd2,
        OUT_INTR    = 2'd3
    } uscite_t;

    typedef enum logic [1:0] {
        ACK_IDLE = 2'd0,
        ACK_HIGH = 2'd1,
        ACK_HOLD = 2'd2
    } ack_state_t;

    localparam int DEFAULT_TIMEOUT = 9;

endpackage

// File: rtl/req_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous request line.
module req_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of the one before it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/intr_compare_unit.sv
// Request select, timeout counter, acknowledge pulse stretcher and protocol
// monitor serving the interrupt-handshake controller.
module intr_compare_unit
    import intr_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_MIN     = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ENIN_REQ,
    input  logic       INTR_REQ,
    input  logic       ACKIN_REQ,
    input  logic [1:0] CC_MUX,
    input  logic       ENABLE_COUNT,
    input  logic       ACKOUT,
    input  logic [1:0] USCITE,
    output logic       EQL,
    output logic       CONT_EQL,
    output logic       ACK_LINE,
    output logic       PROT_ERR
);

    localparam int HCNT_W = $clog2(ACK_MIN + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [HCNT_W-1:0] ACK_MIN_V = HCNT_W'(ACK_MIN);

    if (TIMEOUT < 1 || TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_timeout
        $error("intr_compare_unit: TIMEOUT outside 1..2^CNT_W-1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("intr_compare_unit: SYNC_STAGES must be at least 2");
    end
    if (ACK_MIN < 1) begin : g_bad_ack_min
        $error("intr_compare_unit: ACK_MIN must be at least 1");
    end

    logic w_enin_s;
    logic w_intr_s;
    logic w_ackin_s;

    req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_enin (
        .i_clk(clock), .i_rst_n(reset_n), .i_async(ENIN_REQ), .o_sync(w_enin_s)
    );
    req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_intr (
        .i_clk(clock), .i_rst_n(reset_n), .i_async(INTR_REQ), .o_sync(w_intr_s)
    );
    req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ackin (
        .i_clk(clock), .i_rst_n(reset_n), .i_async(ACKIN_REQ), .o_sync(w_ackin_s)
    );

    logic             r_eql;
    logic             r_cont_eql;
    logic             r_prot_err;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_eql_next;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_eql_next = 1'b0;
        case (cc_sel_t'(CC_MUX))
            CC_ENIN:  w_eql_next = w_enin_s;
            CC_INTR:  w_eql_next = w_intr_s;
            CC_ACKIN: w_eql_next = w_ackin_s;
            default:  w_eql_next = 1'b0;
        endcase

        w_cnt_next = '0;
        if (ENABLE_COUNT) begin
            w_cnt_next = (r_cnt < TIMEOUT_V) ? r_cnt + CNT_W'(1) : r_cnt;
        end
    end

    // CONT_EQL looks at the next count so it rises on the edge cnt reaches TIMEOUT.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_eql      <= 1'b0;
            r_cnt      <= '0;
            r_cont_eql <= 1'b0;
            r_prot_err <= 1'b0;
        end else begin
            r_eql      <= w_eql_next;
            r_cnt      <= w_cnt_next;
            r_cont_eql <= (w_cnt_next == TIMEOUT_V);
            if ((USCITE == OUT_ILLEGAL) || (ENABLE_COUNT != ACKOUT)) begin
                r_prot_err <= 1'b1;
            end
        end
    end

    ack_state_t        r_ack_state;
    logic [HCNT_W-1:0] r_hcnt;
    logic              r_ack_line;

    // hcnt counts cycles ACK_LINE has been high; HOLD stretches short requests to ACK_MIN.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ack_state <= ACK_IDLE;
            r_hcnt      <= '0;
            r_ack_line  <= 1'b0;
        end else begin
            case (r_ack_state)
                ACK_IDLE: begin
                    if (ACKOUT) begin
                        r_ack_state <= ACK_HIGH;
                        r_hcnt      <= HCNT_W'(1);
                        r_ack_line  <= 1'b1;
                    end
                end
                ACK_HIGH: begin
                    if (r_hcnt < ACK_MIN_V) begin
                        r_hcnt <= r_hcnt + HCNT_W'(1);
                    end
                    if (!ACKOUT) begin
                        if (r_hcnt >= ACK_MIN_V) begin
                            r_ack_state <= ACK_IDLE;
                            r_hcnt      <= '0;
                            r_ack_line  <= 1'b0;
                        end else begin
                            r_ack_state <= ACK_HOLD;
                        end
                    end
                end
                ACK_HOLD: begin
                    if (ACKOUT) begin
                        r_ack_state <= ACK_HIGH;
                    end else if (r_hcnt >= ACK_MIN_V) begin
                        r_ack_state <= ACK_IDLE;
                        r_hcnt      <= '0;
                        r_ack_line  <= 1'b0;
                    end else begin
                        r_hcnt <= r_hcnt + HCNT_W'(1);
                    end
                end
                default: begin
                    r_ack_state <= ACK_IDLE;
                    r_hcnt      <= '0;
                    r_ack_line  <= 1'b0;
                end
            endcase
        end
    end

    assign EQL      = r_eql;
    assign CONT_EQL = r_cont_eql;
    assign ACK_LINE = r_ack_line;
    assign PROT_ERR = r_prot_err;

endmodule

// File: tb/tb_intr_compare_unit.sv
// Directed bench for intr_compare_unit; expected output vectors are queued per
// cycle and compared after each rising edge.
module tb_intr_compare_unit;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       ENIN_REQ, INTR_REQ, ACKIN_REQ;
    logic [1:0] CC_MUX;
    logic       ENABLE_COUNT, ACKOUT;
    logic [1:0] USCITE;
    logic       EQL, CONT_EQL, ACK_LINE, PROT_ERR;

    intr_compare_unit #(
        .CNT_W(4), .TIMEOUT(9), .SYNC_STAGES(2), .ACK_MIN(3)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .ENIN_REQ(ENIN_REQ), .INTR_REQ(INTR_REQ), .ACKIN_REQ(ACKIN_REQ),
        .CC_MUX(CC_MUX), .ENABLE_COUNT(ENABLE_COUNT), .ACKOUT(ACKOUT),
        .USCITE(USCITE),
        .EQL(EQL), .CONT_EQL(CONT_EQL), .ACK_LINE(ACK_LINE), .PROT_ERR(PROT_ERR)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [3:0] exp;   // {PROT_ERR, ACK_LINE, CONT_EQL, EQL}
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int checks   = 0;
    int failures = 0;

    // Queue the expectation for the coming edge, clock it, then compare #1 after.
    task automatic cyc(input string tag, input logic [3:0] exp);
        sb_entry_t e;
        sb_entry_t got;
        logic [3:0] obs;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        got = sb_q.pop_front();
        obs = {PROT_ERR, ACK_LINE, CONT_EQL, EQL};
        checks++;
        assert (obs === got.exp) else begin
            failures++;
            $error("FAIL %s observed={P,A,C,E}=%b expected=%b", got.tag, obs, got.exp);
        end
    endtask

    task automatic cycn(input string tag, input logic [3:0] exp, input int n);
        for (int i = 0; i < n; i++) cyc($sformatf("%s[%0d]", tag, i), exp);
    endtask

    task automatic set_ctl(input logic en, input logic ack);
        ENABLE_COUNT = en;
        ACKOUT       = ack;
    endtask

    initial begin
        reset_n = 1'b0;
        ENIN_REQ = 1'b0; INTR_REQ = 1'b0; ACKIN_REQ = 1'b0;
        CC_MUX = 2'b00; USCITE = 2'b00;
        set_ctl(1'b0, 1'b0);

        // Reset held for two cycles.
        cycn("reset_hold", 4'b0000, 2);
        reset_n = 1'b1;

        // EQL: raw INTR edge reaches EQL three edges later.
        INTR_REQ = 1'b1; CC_MUX = 2'b10;
        cycn("intr_sync_lag", 4'b0000, 2);
        cyc("intr_eql_up", 4'b0001);
        CC_MUX = 2'b01;
        cyc("sel_enin_low", 4'b0000);
        // Select and request change together: new select, old synced value.
        ACKIN_REQ = 1'b1; CC_MUX = 2'b11;
        cycn("ackin_sync_lag", 4'b0000, 2);
        cyc("ackin_eql_up", 4'b0001);
        CC_MUX = 2'b00;
        cyc("sel_idle", 4'b0000);
        INTR_REQ = 1'b0; ACKIN_REQ = 1'b0;
        cycn("settle", 4'b0000, 2);

        // Timeout: CONT_EQL on the 9th counting edge, then saturates.
        set_ctl(1'b1, 1'b1);
        cycn("count_pre", 4'b0100, 8);
        cyc("count_hit", 4'b0110);
        cycn("count_sat", 4'b0110, 3);
        set_ctl(1'b0, 1'b0);
        cyc("count_drop", 4'b0000);

        // Mid-count reset at cnt=5 clears everything; count restarts from 0.
        set_ctl(1'b1, 1'b1);
        cycn("mid_pre", 4'b0100, 5);
        reset_n = 1'b0;
        cyc("mid_reset", 4'b0000);
        reset_n = 1'b1;
        cycn("recount_pre", 4'b0100, 8);
        cyc("recount_hit", 4'b0110);
        set_ctl(1'b0, 1'b0);
        cyc("recount_drop", 4'b0000);

        // 1-cycle ACKOUT stretched to exactly 3 high cycles.
        set_ctl(1'b1, 1'b1);
        cyc("pulse1_rise", 4'b0100);
        set_ctl(1'b0, 1'b0);
        cycn("pulse1_hold", 4'b0100, 2);
        cycn("pulse1_low", 4'b0000, 2);

        // 5-cycle ACKOUT followed by 5 high cycles, falling one edge after.
        set_ctl(1'b1, 1'b1);
        cycn("pulse5_high", 4'b0100, 5);
        set_ctl(1'b0, 1'b0);
        cyc("pulse5_fall", 4'b0000);

        // Re-rise during HOLD keeps ACK_LINE continuously high.
        set_ctl(1'b1, 1'b1);
        cyc("rerise_a", 4'b0100);
        set_ctl(1'b0, 1'b0);
        cyc("rerise_gap", 4'b0100);
        set_ctl(1'b1, 1'b1);
        cycn("rerise_b", 4'b0100, 4);
        set_ctl(1'b0, 1'b0);
        cyc("rerise_fall", 4'b0000);

        // Illegal USCITE code latches PROT_ERR until reset.
        USCITE = 2'b10;
        cyc("illegal_set", 4'b1000);
        USCITE = 2'b01;
        cycn("illegal_sticky", 4'b1000, 2);
        reset_n = 1'b0;
        cyc("illegal_reset", 4'b0000);
        reset_n = 1'b1;
        USCITE = 2'b00;
        cyc("clean_after_reset", 4'b0000);

        // ENABLE_COUNT without ACKOUT.
        set_ctl(1'b1, 1'b0);
        cyc("en_no_ack", 4'b1000);
        set_ctl(1'b0, 1'b0);
        cyc("en_no_ack_sticky", 4'b1000);
        reset_n = 1'b0;
        cyc("en_no_ack_reset", 4'b0000);
        reset_n = 1'b1;

        // ACKOUT without ENABLE_COUNT, with the ACK stretch still running.
        set_ctl(1'b0, 1'b1);
        cyc("ack_no_en", 4'b1100);
        set_ctl(1'b0, 1'b0);
        cycn("ack_no_en_hold", 4'b1100, 2);
        cyc("ack_no_en_low", 4'b1000);

        // Reset wins over a simultaneous set condition.
        USCITE = 2'b10;
        reset_n = 1'b0;
        cyc("reset_priority", 4'b0000);
        reset_n = 1'b1;
        USCITE = 2'b00;
        cyc("final_idle", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intr_compare_unit.md
Name: intr_compare_unit

Overview:
- Datapath companion to the interrupt-handshake controller. It produces the controller's EQL and CONT_EQL inputs and consumes its CC_MUX, ENABLE_COUNT, ACKOUT and USCITE outputs.
- Synchronizes three external request lines and selects one per CC_MUX to form EQL.
- Runs the timeout counter gated by ENABLE_COUNT, drives the external acknowledge line with a minimum pulse width, and flags controller protocol violations.

Parameters:
- CNT_W, 4: timeout counter width.
- TIMEOUT, 9: count value at which CONT_EQL asserts. Legal range 1..2^CNT_W-1; out-of-range is an elaboration error.
- SYNC_STAGES, 2: synchronizer depth per request line, >=2.
- ACK_MIN, 3: minimum ACK_LINE high time in cycles, >=1.

Ports:
- clock, in, 1: single clock, all flops posedge.
- reset_n, in, 1: synchronous active-low reset.
- ENIN_REQ, in, 1: raw enable-in request, asynchronous.
- INTR_REQ, in, 1: raw interrupt request, asynchronous.
- ACKIN_REQ, in, 1: raw acknowledge-in, asynchronous.
- CC_MUX, in, 2: source select from controller.
- ENABLE_COUNT, in, 1: counter enable from controller.
- ACKOUT, in, 1: acknowledge request from controller.
- USCITE, in, 2: controller output code, monitored only.
- EQL, out, 1: selected synchronized request, registered.
- CONT_EQL, out, 1: timeout reached, registered.
- ACK_LINE, out, 1: external acknowledge, registered.
- PROT_ERR, out, 1: sticky protocol-violation flag.

Behaviour:
- Reset:
  - Clock with reset_n=0 clears all flops, including synchronizer stages, cnt, and the ACK FSM (to IDLE).
  - EQL, CONT_EQL, ACK_LINE and PROT_ERR are 0 from the first edge with reset_n=0.
  - Mid-operation reset drops all state on that edge with no drain.
- Sync:
  - Each REQ passes through SYNC_STAGES flops, giving enin_s, intr_s and ackin_s.
- EQL:
  - Registered select: 2'b00 gives 0, 2'b01 gives enin_s, 2'b10 gives intr_s, 2'b11 gives ackin_s.
  - Latency from CC_MUX change to EQL is 1 cycle.
  - Latency from raw REQ edge to EQL is SYNC_STAGES+1 cycles.
- Counter:
  - cnt is CNT_W bits, reset 0.
  - ENABLE_COUNT=0: cnt<=0.
  - ENABLE_COUNT=1 and cnt<TIMEOUT: cnt<=cnt+1.
  - cnt==TIMEOUT: hold (saturate, never wraps).
  - CONT_EQL<=(cnt_next==TIMEOUT). It therefore rises on the same edge cnt reaches TIMEOUT.
  - ENABLE_COUNT dropping clears cnt and CONT_EQL on the same edge.
- ACK FSM: states IDLE, HIGH, HOLD. ACK_LINE=1 in HIGH and HOLD.
  - IDLE -> HIGH when ACKOUT=1. hcnt<=1.
  - HIGH: hcnt increments, saturating at ACK_MIN.
    - ACKOUT=0 and hcnt>=ACK_MIN -> IDLE.
    - ACKOUT=0 and hcnt<ACK_MIN -> HOLD.
  - HOLD: hcnt increments.
    - ACKOUT=1 -> HIGH, keeping hcnt.
    - hcnt reaches ACK_MIN -> IDLE.
  - ACK_LINE rises 1 cycle after ACKOUT rises.
  - ACK_LINE falls 1 cycle after ACKOUT falls, but never before ACK_MIN high cycles.
  - An ACKOUT re-rise in HOLD keeps ACK_LINE continuously high, with no glitch.
- PROT_ERR:
  - Set on any edge where USCITE==2'b10 or ENABLE_COUNT!=ACKOUT.
  - Cleared only by reset.
  - Set and clear priority: reset wins.
- Simultaneous events:
  - CC_MUX change and REQ change in the same cycle: EQL uses the new CC_MUX with the already-synchronized value.
  - ENABLE_COUNT rise while cnt==0: first increment on that edge.

Decomposition:
- Shared package intr_pkg:
  - CC codes: CC_IDLE=2'b00, CC_ENIN=2'b01, CC_INTR=2'b10, CC_ACKIN=2'b11.
  - USCITE codes: OUT_NONE=0, OUT_NORM=1, OUT_ILLEGAL=2, OUT_INTR=3.
  - ack_state_t enum.
  - Default TIMEOUT.
- One sub-module, req_sync: parameterized SYNC_STAGES-deep single-bit synchronizer with synchronous active-low reset. Instantiated three times.

Test Plan:
- Reset then hold: with reset_n=0 for 2 cycles, all outputs are 0. Assert reset_n=0 mid-count at cnt=5 -> next edge CONT_EQL=0 and cnt=0.
- EQL select: INTR_REQ=1, CC_MUX=2'b10 -> EQL=1 exactly 3 cycles after the REQ edge (SYNC_STAGES=2). Switch CC_MUX to 2'b01 with ENIN_REQ=0 -> EQL=0 after 1 cycle.
- Timeout: hold ENABLE_COUNT=1 and ACKOUT=1 -> CONT_EQL=1 on the 9th edge and stays 1 (saturated). Drop ENABLE_COUNT -> CONT_EQL=0 next edge.
- ACK pulse: 1-cycle ACKOUT pulse -> ACK_LINE high exactly 3 cycles. 5-cycle ACKOUT -> ACK_LINE high 5 cycles, lagging by 1.
- ACK re-rise: ACKOUT high 1 cycle, low 1 cycle, high 4 cycles -> ACK_LINE continuously high with no 0 cycle.
- Protocol: USCITE=2'b10 for one cycle -> PROT_ERR=1 and stays 1. Separately, ENABLE_COUNT=1 with ACKOUT=0 -> PROT_ERR=1. Only reset clears it.
